// File: rtl/spi_frame_if.sv
// -----------------------------------------------------------------------------
// spi_frame_if
//   SPI slave front-end for start/done accelerator cores. The MCU shifts an
//   IN_BITS operand frame in (MSB first) while 'load' is high. Dropping 'load'
//   starts the core. The captured result is then shifted out on 'sdo' (MSB
//   first), advancing on each sck fall. sck, sdi and load are oversampled in
//   the clk domain; sck is never used as a clock.
//
//   Optional build macro: SPI_FRAME_CHECK_EN adds the 'frame_err' output and
//   rejects frames whose bit count differs from IN_BITS.
//
// Ports
//   clk          system clock (only clock in the block)
//   reset_n      synchronous, active-low reset
//   sck/sdi/load SPI clock, data in and frame strobe from the MCU (async)
//   sdo          SPI data out to the MCU
//   done         result ready for readout
//   core_in      operand to the core, held until the next load rise
//   core_start   one-cycle start pulse to the core
//   core_result  core result, captured while core_done is high in WAIT_CORE
//   core_done    core completion (pulse or level)
//   frame_err    (SPI_FRAME_CHECK_EN only) last frame had the wrong length
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_frame_if #(
    parameter int IN_BITS     = 256,
    parameter int OUT_BITS    = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sck,
    input  logic                sdi,
    input  logic                load,
    output logic                sdo,
    output logic                done,
    output logic [IN_BITS-1:0]  core_in,
    output logic                core_start,
    input  logic [OUT_BITS-1:0] core_result,
    input  logic                core_done
`ifdef SPI_FRAME_CHECK_EN
    ,
    output logic                frame_err
`endif
);

    // in_cnt saturates at IN_BITS+1 so an over-long frame stays distinguishable
    localparam int IN_CW  = $clog2(IN_BITS + 2);
    localparam int OUT_CW = $clog2(OUT_BITS + 1);
    localparam logic [IN_CW-1:0]  IN_SAT   = IN_CW'(IN_BITS + 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BITS);
`ifdef SPI_FRAME_CHECK_EN
    localparam logic [IN_CW-1:0]  IN_FULL  = IN_CW'(IN_BITS);
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_IN  = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_CORE = 3'd3,
        ST_SHIFT_OUT = 3'd4
    } state_t;

    // synchronisers and edge-detect copies
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] sdi_sync_r;
    logic [SYNC_STAGES-1:0] load_sync_r;
    logic                   sck_d_r;
    logic                   load_d_r;

    // state and datapath registers with their next values
    state_t                 state_r,     state_s;
    logic [IN_CW-1:0]       in_cnt_r,    in_cnt_s;
    logic [OUT_CW-1:0]      out_cnt_r,   out_cnt_s;
    logic [IN_BITS-1:0]     core_in_r,   core_in_s;
    logic [OUT_BITS-1:0]    out_shreg_r, out_shreg_s;
    logic                   sdo_r,       sdo_s;
    logic                   done_r,      done_s;
    logic                   core_start_r, core_start_s;
`ifdef SPI_FRAME_CHECK_EN
    logic                   frame_err_r, frame_err_s;
`endif

    logic                   sck_now_s;
    logic                   load_now_s;
    logic                   sck_rise_s;
    logic                   sck_fall_s;
    logic                   load_rise_s;
    logic                   load_fall_s;
    logic [IN_BITS-1:0]     core_in_shift_s;
    logic [IN_CW-1:0]       in_cnt_inc_s;
    logic [OUT_BITS-1:0]    out_shift_s;

    assign sck_now_s       = sck_sync_r[SYNC_STAGES-1];
    assign load_now_s      = load_sync_r[SYNC_STAGES-1];
    assign sck_rise_s      = sck_now_s & ~sck_d_r;
    assign sck_fall_s      = ~sck_now_s & sck_d_r;
    assign load_rise_s     = load_now_s & ~load_d_r;
    assign load_fall_s     = ~load_now_s & load_d_r;
    assign core_in_shift_s = {core_in_r[IN_BITS-2:0], sdi_sync_r[SYNC_STAGES-1]};
    assign in_cnt_inc_s    = (in_cnt_r == IN_SAT) ? in_cnt_r : (in_cnt_r + IN_CW'(1));
    // written as a shift so OUT_BITS=1 needs no special case; zero fill
    // guarantees sdo reads 0 once the whole result has been shifted out
    assign out_shift_s     = out_shreg_r << 1'b1;

    // Next-state and datapath decode; a load edge is handled before any sck edge
    always_comb begin
        state_s      = state_r;
        in_cnt_s     = in_cnt_r;
        out_cnt_s    = out_cnt_r;
        core_in_s    = core_in_r;
        out_shreg_s  = out_shreg_r;
        sdo_s        = sdo_r;
        done_s       = done_r;
        core_start_s = 1'b0;
`ifdef SPI_FRAME_CHECK_EN
        frame_err_s  = frame_err_r;
`endif

        if (load_rise_s && (state_r != ST_SHIFT_IN)) begin
            // new frame aborts whatever was in progress, including a pending result
            state_s   = ST_SHIFT_IN;
            out_cnt_s = '0;
            done_s    = 1'b0;
            sdo_s     = 1'b0;
`ifdef SPI_FRAME_CHECK_EN
            frame_err_s = 1'b0;
`endif
            // a coincident sck rise already belongs to the new frame
            if (sck_rise_s) begin
                core_in_s = core_in_shift_s;
                in_cnt_s  = IN_CW'(1);
            end else begin
                in_cnt_s  = '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_SHIFT_IN: begin
                    if (load_fall_s) begin
`ifdef SPI_FRAME_CHECK_EN
                        if (in_cnt_r == IN_FULL) begin
                            state_s      = ST_START;
                            core_start_s = 1'b1;
                        end else begin
                            state_s      = ST_IDLE;
                            frame_err_s  = 1'b1;
                        end
`else
                        state_s      = ST_START;
                        core_start_s = 1'b1;
`endif
                    end else if (sck_rise_s) begin
                        core_in_s = core_in_shift_s;
                        in_cnt_s  = in_cnt_inc_s;
                    end else begin
                        state_s   = ST_SHIFT_IN;
                    end
                end
                ST_START: begin
                    state_s = ST_WAIT_CORE;
                end
                ST_WAIT_CORE: begin
                    if (core_done) begin
                        out_shreg_s = core_result;
                        sdo_s       = core_result[OUT_BITS-1];
                        done_s      = 1'b1;
                        out_cnt_s   = '0;
                        state_s     = ST_SHIFT_OUT;
                    end else begin
                        state_s     = ST_WAIT_CORE;
                    end
                end
                ST_SHIFT_OUT: begin
                    if (sck_fall_s && (out_cnt_r != OUT_LAST)) begin
                        out_shreg_s = out_shift_s;
                        sdo_s       = out_shift_s[OUT_BITS-1];
                        out_cnt_s   = out_cnt_r + OUT_CW'(1);
                    end else begin
                        state_s     = ST_SHIFT_OUT;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Synchronisers, edge-detect copies, FSM state and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_sync_r   <= '0;
            sdi_sync_r   <= '0;
            load_sync_r  <= '0;
            sck_d_r      <= 1'b0;
            load_d_r     <= 1'b0;
            state_r      <= ST_IDLE;
            in_cnt_r     <= '0;
            out_cnt_r    <= '0;
            core_in_r    <= '0;
            out_shreg_r  <= '0;
            sdo_r        <= 1'b0;
            done_r       <= 1'b0;
            core_start_r <= 1'b0;
`ifdef SPI_FRAME_CHECK_EN
            frame_err_r  <= 1'b0;
`endif
        end else begin
            sck_sync_r   <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            sdi_sync_r   <= {sdi_sync_r[SYNC_STAGES-2:0], sdi};
            load_sync_r  <= {load_sync_r[SYNC_STAGES-2:0], load};
            sck_d_r      <= sck_now_s;
            load_d_r     <= load_now_s;
            state_r      <= state_s;
            in_cnt_r     <= in_cnt_s;
            out_cnt_r    <= out_cnt_s;
            core_in_r    <= core_in_s;
            out_shreg_r  <= out_shreg_s;
            sdo_r        <= sdo_s;
            done_r       <= done_s;
            // registered alongside the move into START, so it is high exactly
            // for the single cycle spent in START
            core_start_r <= core_start_s;
`ifdef SPI_FRAME_CHECK_EN
            frame_err_r  <= frame_err_s;
`endif
        end
    end

    assign sdo        = sdo_r;
    assign done       = done_r;
    assign core_in    = core_in_r;
    assign core_start = core_start_r;
`ifdef SPI_FRAME_CHECK_EN
    assign frame_err  = frame_err_r;
`endif

endmodule

// File: tb/tb_spi_frame_if.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_if
//   Bench for spi_frame_if. Two instances: the AES-sized default (256/128)
//   with a known-answer core model, and a 16/8 instance whose core returns the
//   bitwise NOT of core_in[7:0] as a held level. Expected operands/results are
//   queued when a frame is driven and popped when the DUT starts the core or
//   presents a result.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_frame_if;

    localparam int HALF = 5;   // sck half period in clk cycles
    localparam int SYNC = 2;

    localparam logic [255:0] VEC1 = {128'h3243F6A8885A308D313198A2E0370734,
                                     128'h2B7E151628AED2A6ABF7158809CF4F3C};
    localparam logic [127:0] CT1  = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [255:0] VEC2 = {128'h00112233445566778899AABBCCDDEEFF,
                                     128'h000102030405060708090A0B0C0D0E0F};
    localparam logic [127:0] CT2  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic         b_sck, b_sdi, b_load, b_sdo, b_done, b_core_start, b_core_done;
    logic [255:0] b_core_in;
    logic [127:0] b_core_result;
    logic [4:0]   b_cd_cnt;

    logic         s_sck, s_sdi, s_load, s_sdo, s_done, s_core_start, s_core_done;
    logic [15:0]  s_core_in;
    logic [7:0]   s_core_result;
    logic [2:0]   s_cd_cnt;

`ifdef SPI_FRAME_CHECK_EN
    logic b_frame_err, s_frame_err;
`endif

    spi_frame_if #(.IN_BITS(256), .OUT_BITS(128), .SYNC_STAGES(SYNC)) u_big (
        .clk(clk), .reset_n(reset_n), .sck(b_sck), .sdi(b_sdi), .load(b_load),
        .sdo(b_sdo), .done(b_done), .core_in(b_core_in), .core_start(b_core_start),
        .core_result(b_core_result), .core_done(b_core_done)
`ifdef SPI_FRAME_CHECK_EN
        , .frame_err(b_frame_err)
`endif
    );

    spi_frame_if #(.IN_BITS(16), .OUT_BITS(8), .SYNC_STAGES(SYNC)) u_small (
        .clk(clk), .reset_n(reset_n), .sck(s_sck), .sdi(s_sdi), .load(s_load),
        .sdo(s_sdo), .done(s_done), .core_in(s_core_in), .core_start(s_core_start),
        .core_result(s_core_result), .core_done(s_core_done)
`ifdef SPI_FRAME_CHECK_EN
        , .frame_err(s_frame_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int b_starts = 0;
    int s_starts = 0;

    logic [255:0] b_exp_in_q[$];
    logic [127:0] b_exp_out_q[$];
    logic [15:0]  s_exp_in_q[$];
    logic [7:0]   s_exp_out_q[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // known-answer AES stand-in
    function automatic logic [127:0] aes_model(input logic [255:0] v);
        if (v == VEC1)      return CT1;
        else if (v == VEC2) return CT2;
        else                return v[255:128] ^ v[127:0];
    endfunction

    // big core: single-cycle done pulse 10 cycles after start
    always @(posedge clk) begin
        if (!reset_n) begin
            b_cd_cnt <= 5'd0; b_core_done <= 1'b0; b_core_result <= '0;
        end else begin
            b_core_done <= 1'b0;
            if (b_core_start) begin
                b_cd_cnt <= 5'd10;
            end else if (b_cd_cnt != 5'd0) begin
                b_cd_cnt <= b_cd_cnt - 5'd1;
                if (b_cd_cnt == 5'd1) begin
                    b_core_done   <= 1'b1;
                    b_core_result <= aes_model(b_core_in);
                end
            end
        end
    end

    // small core: done level raised 3 cycles after start and held
    always @(posedge clk) begin
        if (!reset_n) begin
            s_cd_cnt <= 3'd0; s_core_done <= 1'b0; s_core_result <= '0;
        end else if (s_core_start) begin
            s_cd_cnt <= 3'd3; s_core_done <= 1'b0;
        end else if (s_cd_cnt != 3'd0) begin
            s_cd_cnt <= s_cd_cnt - 3'd1;
            if (s_cd_cnt == 3'd1) begin
                s_core_done   <= 1'b1;
                s_core_result <= ~s_core_in[7:0];
            end
        end
    end

    // start monitors: pop the expected operand on every core_start
    always @(negedge clk) begin
        if (reset_n && b_core_start) begin
            b_starts <= b_starts + 1;
            if (b_exp_in_q.size() == 0) check("b_spurious_start", {255'd0, b_core_start}, 256'd0);
            else                        check("b_core_in", b_core_in, b_exp_in_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (reset_n && s_core_start) begin
            s_starts <= s_starts + 1;
            if (s_exp_in_q.size() == 0) check("s_spurious_start", {255'd0, s_core_start}, 256'd0);
            else                        check("s_core_in", {240'd0, s_core_in}, {240'd0, s_exp_in_q.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sck(input bit sel, input logic v);
        if (sel) s_sck = v; else b_sck = v;
    endtask
    task automatic set_sdi(input bit sel, input logic v);
        if (sel) s_sdi = v; else b_sdi = v;
    endtask
    task automatic set_load(input bit sel, input logic v);
        if (sel) s_load = v; else b_load = v;
    endtask
    function automatic logic cur_sdo(input bit sel);
        return sel ? s_sdo : b_sdo;
    endfunction
    function automatic logic cur_done(input bit sel);
        return sel ? s_done : b_done;
    endfunction

    task automatic drive_bits(input bit sel, input logic [259:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            set_sdi(sel, bits[i]);
            tick(HALF);
            set_sck(sel, 1'b1);
            tick(HALF);
            set_sck(sel, 1'b0);
        end
    endtask

    task automatic send_frame(input bit sel, input logic [259:0] bits, input int n);
        set_load(sel, 1'b1);
        tick(HALF);
        drive_bits(sel, bits, n);
        tick(HALF);
        set_load(sel, 1'b0);
        tick(HALF);
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int k = 0;
        while (!cur_done(sel) && k < 200) begin
            tick(1);
            k++;
        end
        check(tag, {255'd0, cur_done(sel)}, 256'd1);
    endtask

    // MCU samples sdo just before each sck rise
    task automatic read_bits(input bit sel, input int n, output logic [127:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            r = {r[126:0], cur_sdo(sel)};
            set_sck(sel, 1'b1);
            tick(HALF);
            set_sck(sel, 1'b0);
            tick(HALF);
        end
    endtask

    task automatic big_readout(input string tag);
        logic [127:0] r;
        logic [127:0] e;
        e = b_exp_out_q.pop_front();
        read_bits(1'b0, 128, r);
        check({tag, "_readout"}, {128'd0, r}, {128'd0, e});
        check({tag, "_sdo_after_last"}, {255'd0, b_sdo}, 256'd0);
        check({tag, "_done_held"}, {255'd0, b_done}, 256'd1);
    endtask

    task automatic big_txn(input logic [259:0] bits, input int n,
                           input logic [255:0] exp_in, input string tag);
        int s0;
        b_exp_in_q.push_back(exp_in);
        b_exp_out_q.push_back(aes_model(exp_in));
        s0 = b_starts;
        send_frame(1'b0, bits, n);
        wait_done(1'b0, {tag, "_done"});
        check({tag, "_start_count"}, 256'(b_starts - s0), 256'd1);
        big_readout(tag);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation exceeded 1 ms");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int k;
        logic [127:0] r;
        logic [127:0] e;

        reset_n = 1'b0;
        b_sck = 1'b0; b_sdi = 1'b0; b_load = 1'b0;
        s_sck = 1'b0; s_sdi = 1'b0; s_load = 1'b0;
        tick(3);
        check("rst_sdo",        {255'd0, b_sdo},        256'd0);
        check("rst_done",       {255'd0, b_done},       256'd0);
        check("rst_core_start", {255'd0, b_core_start}, 256'd0);
        check("rst_core_in",    b_core_in,              256'd0);
        check("rst_s_sdo",      {255'd0, s_sdo},        256'd0);
        reset_n = 1'b1;
        tick(3);

        // full AES known-answer transaction
        big_txn(260'(VEC1), 256, VEC1, "aes1");

        // reset at bit 100 of a shift-in
        s0 = b_starts;
        set_load(1'b0, 1'b1);
        tick(HALF);
        drive_bits(1'b0, 260'(VEC1 >> 156), 100);
        reset_n = 1'b0; b_load = 1'b0; b_sck = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("midrst_sdo",        {255'd0, b_sdo},        256'd0);
        check("midrst_done",       {255'd0, b_done},       256'd0);
        check("midrst_core_start", {255'd0, b_core_start}, 256'd0);
        check("midrst_core_in",    b_core_in,              256'd0);
        tick(30);
        check("midrst_no_start", 256'(b_starts - s0), 256'd0);
        big_txn(260'(VEC2), 256, VEC2, "after_rst");

        // load rise during readout at bit 40, then the C.1 frame
        b_exp_in_q.push_back(VEC1);
        b_exp_out_q.push_back(CT1);
        send_frame(1'b0, 260'(VEC1), 256);
        wait_done(1'b0, "abort_done");
        e = b_exp_out_q.pop_front();
        read_bits(1'b0, 40, r);
        check("abort_partial", {216'd0, r[39:0]}, {216'd0, e[127:88]});
        set_load(1'b0, 1'b1);
        k = 0;
        while (b_done && k < SYNC + 2) begin
            tick(1);
            k++;
        end
        check("abort_done_clr", {255'd0, b_done}, 256'd0);
        check("abort_sdo_clr",  {255'd0, b_sdo},  256'd0);
        b_exp_in_q.push_back(VEC2);
        b_exp_out_q.push_back(CT2);
        s0 = b_starts;
        tick(HALF);
        drive_bits(1'b0, 260'(VEC2), 256);
        tick(HALF);
        set_load(1'b0, 1'b0);
        tick(HALF);
        wait_done(1'b0, "c1_done");
        check("c1_start_count", 256'(b_starts - s0), 256'd1);
        big_readout("c1");

`ifdef SPI_FRAME_CHECK_EN
        // length-checked frames
        s0 = b_starts;
        send_frame(1'b0, 260'(VEC1), 255);
        tick(20);
        check("short_frame_err", {255'd0, b_frame_err}, 256'd1);
        check("short_no_start",  256'(b_starts - s0),   256'd0);
        send_frame(1'b0, 260'({VEC1, 1'b1}), 257);
        tick(20);
        check("long_frame_err",  {255'd0, b_frame_err}, 256'd1);
        check("long_no_start",   256'(b_starts - s0),   256'd0);
        big_txn(260'(VEC1), 256, VEC1, "good_after_err");
        check("frame_err_clr",   {255'd0, b_frame_err}, 256'd0);
`else
        // 258-bit frame: two leading junk bits fall off the top
        big_txn(260'({2'b10, VEC2}), 258, VEC2, "long258");
`endif

        // 16/8 instance: NOT core, level core_done
        s_exp_in_q.push_back(16'hA55A);
        s_exp_out_q.push_back(8'hA5);
        s0 = s_starts;
        send_frame(1'b1, 260'h0A55A, 16);
        wait_done(1'b1, "small_done");
        check("small_start_count", 256'(s_starts - s0), 256'd1);
        e = {120'd0, s_exp_out_q.pop_front()};
        read_bits(1'b1, 8, r);
        check("small_readout", {248'd0, r[7:0]}, {248'd0, e[7:0]});
        check("small_sdo_after8", {255'd0, s_sdo}, 256'd0);
        set_sck(1'b1, 1'b1);
        tick(HALF);
        set_sck(1'b1, 1'b0);
        tick(HALF);
        check("small_sdo_9th_fall", {255'd0, s_sdo},  256'd0);
        check("small_done_held",    {255'd0, s_done}, 256'd1);

        tick(5);
        check("b_in_q_empty",  256'(b_exp_in_q.size()),  256'd0);
        check("b_out_q_empty", 256'(b_exp_out_q.size()), 256'd0);
        check("s_in_q_empty",  256'(s_exp_in_q.size()),  256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
